// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for multi_clock_divider and its per-channel divider.
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W       = 16;
  localparam int CLKDIV_DEFAULT_DIV = 1;
  localparam int CLKDIV_MAX_CH      = 16;

  // A single channel still needs a one-bit cfg_ch port.
  function automatic int clkdiv_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor, pending flag, clk_out and tick.
// The sync_pulse input exists only when CLKDIV_PHASE_SYNC_EN is defined.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk_100,
  input  logic             rst,
  input  logic             en,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic             sync_pulse,
`endif
  input  logic             load,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] sdiv_r;
  logic             pending_r;
  logic             clk_out_r;
  logic             tick_r;
  logic             park_s;
  logic             wrap_s;
  logic             apply_s;

  // Parking (disabled or phase-sync) and wrap are the only points a new divisor may land.
  always_comb begin
`ifdef CLKDIV_PHASE_SYNC_EN
    park_s  = ~en | sync_pulse;
`else
    park_s  = ~en;
`endif
    wrap_s  = en & (cnt_r == div_r);
    apply_s = pending_r & (park_s | wrap_s);
  end

  // Half-period counter and output square wave.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
    end else if (park_s) begin
      cnt_r     <= '0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
    end else if (wrap_s) begin
      cnt_r     <= '0;
      clk_out_r <= ~clk_out_r;
      tick_r    <= ~clk_out_r;
    end else begin
      cnt_r     <= cnt_r + CNT_W'(1);
      tick_r    <= 1'b0;
    end
  end

  // Divisor update: load only happens while not pending, so it never collides with apply.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      div_r     <= CNT_W'(DEFAULT_DIV);
      sdiv_r    <= CNT_W'(DEFAULT_DIV);
      pending_r <= 1'b0;
    end else if (load) begin
      sdiv_r    <= cfg_div;
      pending_r <= 1'b1;
    end else if (apply_s) begin
      div_r     <= sdiv_r;
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign pending = pending_r;
  assign clk_out = clk_out_r;
  assign tick    = tick_r;

endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independent divided clocks and ticks from clk_100 with a
// valid/ready divisor update port. Optional sync_pulse input under CLKDIV_PHASE_SYNC_EN.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH      = 2,
  parameter int  CNT_W       = CLKDIV_CNT_W,
  parameter int  DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
  localparam int CH_W        = clkdiv_ch_w(NUM_CH)
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic              sync_pulse,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] load_s;

  // An out-of-range cfg_ch selects no channel: it reads ready and the write is dropped.
  assign cfg_ready = ~|(sel_s & pending_s);
  assign load_s    = sel_s & {NUM_CH{cfg_valid & cfg_ready}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel_s[i] = (cfg_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_100   (clk_100),
      .rst       (rst),
      .en        (en[i]),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync_pulse(sync_pulse),
`endif
      .load      (load_s[i]),
      .cfg_div   (cfg_div),
      .pending   (pending_s[i]),
      .clk_out   (clk_out[i]),
      .tick      (tick[i])
    );
  end

endmodule
